// File: rtl/mmio_data_mem.sv
// mmio_data_mem: word-addressed data RAM plus an I/O window for debounced buttons and a scanned hex display.
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   addr, write, wdata   : datapath word address, write strobe and write data
//   rdata                : registered read data, one cycle after addr
//   in                   : raw button levels, asynchronous to clk
//   seg, an              : active-low segments (bit0 = a) and active-low one-hot digit enables
module mmio_data_mem #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 10,
    parameter int DEPTH        = 1016,
    parameter int NUM_IN       = 1,
    parameter int NUM_DIGITS   = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int SCAN_DIV     = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  write,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    input  logic [NUM_IN-1:0]     in,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    logic [DATA_W-1:0]            mem [DEPTH];
    logic [NUM_IN-1:0]            s1, s2, st, st_nxt, rise, edg, clr;
    logic [NUM_IN-1:0][CW-1:0]    cnt, cnt_nxt;
    logic [DATA_W-1:0]            disp, rd_nxt;
    logic                         ctrl;
    logic [SW-1:0]                sc;
    logic [IW-1:0]                idx;
    logic [3:0]                   nib;
    logic                         is_ram, is_io, wrap;
    logic [2:0]                   off;
    logic [AW-1:0]                ra;

    assign is_ram = addr < ADDR_W'(DEPTH);
    assign is_io  = addr[ADDR_W-1:3] == '1;
    assign off    = addr[2:0];
    assign ra     = addr[AW-1:0];
    assign wrap   = sc == SW'(SCAN_DIV - 1);
    assign nib    = disp[{idx, 2'b00} +: 4];
    assign clr    = (write && is_io && off == 3'd1) ? wdata[NUM_IN-1:0] : '0;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        rd_nxt = is_ram ? mem[ra] :
                 !is_io ? '0 :
                 off == 3'd0 ? DATA_W'(st) :
                 off == 3'd1 ? DATA_W'(edg) :
                 off == 3'd2 ? disp :
                 off == 3'd3 ? DATA_W'(ctrl) : '0;
    end

    // A bit's counter only runs while the synced level disagrees with the accepted level.
    always_comb begin
        st_nxt  = st;
        cnt_nxt = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (s2[i] != st[i]) begin
                if (cnt[i] == CW'(DEBOUNCE_CYC - 1))
                    st_nxt[i] = s2[i];
                else
                    cnt_nxt[i] = cnt[i] + 1'b1;
            end
        end
        rise = st_nxt & ~st;
    end

    always_ff @(posedge clk)
        if (write && is_ram)
            mem[ra] <= wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
            s1    <= '0;
            s2    <= '0;
            st    <= '0;
            cnt   <= '0;
            edg   <= '0;
            disp  <= '0;
            ctrl  <= 1'b0;
            sc    <= '0;
            idx   <= '0;
            seg   <= 7'h7F;
            an    <= '1;
        end else begin
            rdata <= rd_nxt;
            s1    <= in;
            s2    <= s1;
            st    <= st_nxt;
            cnt   <= cnt_nxt;
            // A fresh rising edge beats a simultaneous clear.
            edg   <= (edg & ~clr) | rise;
            if (write && is_io && off == 3'd2)
                disp <= wdata;
            if (write && is_io && off == 3'd3)
                ctrl <= wdata[0];
            sc    <= wrap ? '0 : sc + 1'b1;
            if (wrap)
                idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
            seg   <= ctrl ? hex7(nib) : 7'h7F;
            an    <= ctrl ? ~(NUM_DIGITS'(1) << idx) : '1;
        end
    end
endmodule
